// File: rtl/mtime_initiator_pkg.sv
// Shared encodings for the mtime initiator: command ops, sequencer states,
// timer register addresses and the mtimecmp disarm value.
package mtime_initiator_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_ARM_ABS = 2'b01,
        OP_ARM_REL = 2'b10,
        OP_DISARM  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_HI1   = 3'd1,
        RD_LO    = 3'd2,
        RD_HI2   = 3'd3,
        W_LO_MAX = 3'd4,
        W_HI     = 3'd5,
        W_LO     = 3'd6,
        RESP     = 3'd7
    } state_e;

    // Timer address as {t_reg_sel, t_h_sel}.
    localparam logic [1:0]  MTIME_LO    = 2'b00;
    localparam logic [1:0]  MTIME_HI    = 2'b01;
    localparam logic [1:0]  MTIMECMP_LO = 2'b10;
    localparam logic [1:0]  MTIMECMP_HI = 2'b11;

    localparam logic [63:0] DISARM_VAL  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [31:0] WORD_MAX    = 32'hFFFF_FFFF;

endpackage

// File: rtl/mtime_initiator.sv
// Snapshots the 64-bit mtime over a 32-bit port and rewrites mtimecmp without spurious interrupts.
// Define MTIME_INITIATOR_RETRY_EN to compile in hi-lo-hi re-reads with an error after MAX_RETRY.
module mtime_initiator
    import mtime_initiator_pkg::*;
#(
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        t_reg_sel,
    output logic        t_h_sel,
    output logic [31:0] t_wdata,
    output logic        t_wenable,
    input  logic [31:0] t_rdata
);

    state_e      state_r;
    op_e         op_r;
    logic [63:0] data_r;
    logic [63:0] target_r;
    logic [63:0] rsp_data_r;
    logic [31:0] hi1_r;
    logic [31:0] t_wdata_r;
    logic [1:0]  t_addr_r;
    logic        t_wen_r;
    logic        rsp_valid_r;
    logic        read_done_s;
    logic [63:0] sample_s;

`ifdef MTIME_INITIATOR_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
    logic [RETRY_W-1:0] retry_r;
    logic [31:0]        lo_r;
    logic               rsp_err_r;

    // Snapshot is consistent once the second high read matches the first.
    assign read_done_s = (state_r == RD_HI2) && (t_rdata == hi1_r);
    assign sample_s    = {hi1_r, lo_r};
    assign rsp_err     = rsp_err_r;
`else
    assign read_done_s = (state_r == RD_LO);
    assign sample_s    = {hi1_r, t_rdata};
    assign rsp_err     = 1'b0;
`endif

    assign cmd_ready = (state_r == IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign t_reg_sel = t_addr_r[1];
    assign t_h_sel   = t_addr_r[0];
    assign t_wdata   = t_wdata_r;
    assign t_wenable = t_wen_r & rst_n;

    // Sequencer: command accept, timer reads and writes, response hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= OP_READ;
            data_r      <= 64'h0;
            target_r    <= 64'h0;
            rsp_data_r  <= 64'h0;
            hi1_r       <= 32'h0;
            t_wdata_r   <= 32'h0;
            t_addr_r    <= MTIME_LO;
            t_wen_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
`ifdef MTIME_INITIATOR_RETRY_EN
            retry_r     <= '0;
            lo_r        <= 32'h0;
            rsp_err_r   <= 1'b0;
`endif
        end else begin
            // Timer-side outputs are set on entry to the state that uses them.
            t_addr_r  <= MTIME_LO;
            t_wdata_r <= 32'h0;
            t_wen_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        op_r   <= op_e'(cmd_op);
                        data_r <= cmd_data;
`ifdef MTIME_INITIATOR_RETRY_EN
                        retry_r   <= '0;
                        rsp_err_r <= 1'b0;
`endif
                        if (cmd_op == OP_READ || cmd_op == OP_ARM_REL) begin
                            state_r  <= RD_HI1;
                            t_addr_r <= MTIME_HI;
                        end else begin
                            state_r   <= W_LO_MAX;
                            target_r  <= (cmd_op == OP_DISARM) ? DISARM_VAL : cmd_data;
                            t_addr_r  <= MTIMECMP_LO;
                            t_wdata_r <= WORD_MAX;
                            t_wen_r   <= 1'b1;
                        end
                    end
                end
                RD_HI1: begin
                    hi1_r    <= t_rdata;
                    state_r  <= RD_LO;
                    t_addr_r <= MTIME_LO;
                end
                RD_LO: begin
`ifdef MTIME_INITIATOR_RETRY_EN
                    lo_r     <= t_rdata;
                    state_r  <= RD_HI2;
                    t_addr_r <= MTIME_HI;
`else
                    state_r  <= RD_LO;
`endif
                end
`ifdef MTIME_INITIATOR_RETRY_EN
                RD_HI2: begin
                    if (!read_done_s) begin
                        if (retry_r == RETRY_W'(MAX_RETRY - 1)) begin
                            rsp_err_r  <= 1'b1;
                            rsp_data_r <= {t_rdata, lo_r};
                            state_r    <= RESP;
                        end else begin
                            retry_r  <= retry_r + RETRY_W'(1);
                            hi1_r    <= t_rdata;
                            state_r  <= RD_LO;
                            t_addr_r <= MTIME_LO;
                        end
                    end
                end
`endif
                // Low word parked at all ones first so a half-updated compare never fires early.
                W_LO_MAX: begin
                    state_r   <= W_HI;
                    t_addr_r  <= MTIMECMP_HI;
                    t_wdata_r <= target_r[63:32];
                    t_wen_r   <= 1'b1;
                end
                W_HI: begin
                    state_r   <= W_LO;
                    t_addr_r  <= MTIMECMP_LO;
                    t_wdata_r <= target_r[31:0];
                    t_wen_r   <= 1'b1;
                end
                W_LO: begin
                    rsp_data_r <= target_r;
                    state_r    <= RESP;
                end
                RESP: begin
                    if (!rsp_valid_r) begin
                        rsp_valid_r <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase

            // A finished snapshot either answers READ or seeds the ARM_REL target.
            if (read_done_s) begin
                if (op_r == OP_ARM_REL) begin
                    target_r  <= sample_s + data_r;
                    state_r   <= W_LO_MAX;
                    t_addr_r  <= MTIMECMP_LO;
                    t_wdata_r <= WORD_MAX;
                    t_wen_r   <= 1'b1;
                end else begin
                    rsp_data_r <= sample_s;
                    state_r    <= RESP;
                end
            end
        end
    end

endmodule

// File: tb/tb_mtime_initiator.sv
// Self-checking bench for mtime_initiator against a cycle-accurate timer model.
module tb_mtime_initiator;
    import mtime_initiator_pkg::*;

    localparam int unsigned MR = 3;
`ifdef MTIME_INITIATOR_RETRY_EN
    localparam int LAT_RD  = 4;
    localparam int LAT_REL = 7;
`else
    localparam int LAT_RD  = 3;
    localparam int LAT_REL = 6;
`endif
    localparam int LAT_WR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [63:0] cmd_data = 64'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic        t_reg_sel;
    logic        t_h_sel;
    logic [31:0] t_wdata;
    logic        t_wenable;
    logic [31:0] t_rdata;

    logic [63:0] mtime_m;
    logic [63:0] mtimecmp_m;
    logic        tb_init = 1'b1;
    logic        preload_req = 1'b0;
    logic [63:0] preload_val = 64'h0;
    logic        chaos = 1'b0;
    logic        int_pending;
    int          int_cnt = 0;
    logic [33:0] wr_q[$];

    int n_cmp = 0;
    int n_fail = 0;

    mtime_initiator #(.MAX_RETRY(MR)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .t_reg_sel(t_reg_sel), .t_h_sel(t_h_sel), .t_wdata(t_wdata), .t_wenable(t_wenable),
        .t_rdata(t_rdata)
    );

    always #5 clk = ~clk;

    // Timer model; chaos makes the mtime high word change every cycle.
    assign t_rdata = t_reg_sel ? (t_h_sel ? mtimecmp_m[63:32] : mtimecmp_m[31:0])
                               : (t_h_sel ? (chaos ? mtime_m[31:0] : mtime_m[63:32]) : mtime_m[31:0]);
    assign int_pending = (mtime_m >= mtimecmp_m);

    always @(posedge clk) begin
        if (!rst_n) mtime_m <= 64'h0;
        else if (preload_req) mtime_m <= preload_val;
        else mtime_m <= mtime_m + 64'h1;
        if (tb_init) mtimecmp_m <= 64'hFFFF_FFFF_FFFF_FFFF;
        else if (t_wenable && t_reg_sel) begin
            if (t_h_sel) mtimecmp_m[63:32] <= t_wdata;
            else mtimecmp_m[31:0] <= t_wdata;
        end
        if (t_wenable) wr_q.push_back({t_reg_sel, t_h_sel, t_wdata});
        if (int_pending === 1'b1) int_cnt <= int_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hi_at(input logic [63:0] m, input bit chz);
        return chz ? m[31:0] : m[63:32];
    endfunction

    // Reference snapshot: m0 is mtime in the first read cycle, advancing one per cycle.
    function automatic void ref_read(input logic [63:0] m0, input bit chz,
                                     output logic [63:0] smp, output bit err, output int nret);
        logic [31:0] hi1;
        logic [63:0] m;
        hi1 = hi_at(m0, chz);
        err = 1'b0;
        nret = 0;
        smp = 64'h0;
`ifdef MTIME_INITIATOR_RETRY_EN
        for (int r = 0; r < int'(MR); r++) begin
            logic [31:0] hi2;
            m = m0 + 64'(2 * r + 1);
            hi2 = hi_at(m0 + 64'(2 * r + 2), chz);
            nret = r;
            if (hi2 == hi1) begin
                smp = {hi1, m[31:0]};
                return;
            end
            if (r == int'(MR) - 1) begin
                err = 1'b1;
                smp = {hi2, m[31:0]};
                return;
            end
            hi1 = hi2;
        end
`else
        m = m0 + 64'h1;
        smp = {hi1, m[31:0]};
`endif
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [63:0] data, input bit do_pre,
                           input logic [63:0] pre, input bit chz, input int rdy_dly,
                           input bit junk, output logic [63:0] got);
        logic [63:0] m0, smp, tgt, exp_data, held;
        logic [33:0] exp_w[3];
        bit err, exp_err;
        int nret, exp_lat, exp_nw, lat, wstart;
        chk("idle_ready", {63'h0, cmd_ready}, 64'h1);
        wstart = wr_q.size();
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        preload_req = do_pre; preload_val = pre; chaos = chz;
        rsp_ready = (rdy_dly == 0);
        tick();
        m0 = mtime_m;
        preload_req = 1'b0;
        if (junk) begin
            cmd_op = ~op; cmd_data = ~data;
        end else begin
            cmd_valid = 1'b0;
        end
        chk("busy_ready", {63'h0, cmd_ready}, 64'h0);
        ref_read(m0, chz, smp, err, nret);
        tgt = 64'h0;
        case (op)
            2'b00: begin exp_data = smp; exp_err = err; exp_lat = LAT_RD + 2 * nret; exp_nw = 0; end
            2'b10: begin
                if (err) begin
                    exp_data = smp; exp_err = 1'b1; exp_lat = LAT_RD + 2 * nret; exp_nw = 0;
                end else begin
                    tgt = smp + data; exp_data = tgt; exp_err = 1'b0;
                    exp_lat = LAT_REL + 2 * nret; exp_nw = 3;
                end
            end
            2'b01: begin tgt = data; exp_data = tgt; exp_err = 1'b0; exp_lat = LAT_WR; exp_nw = 3; end
            default: begin tgt = '1; exp_data = tgt; exp_err = 1'b0; exp_lat = LAT_WR; exp_nw = 3; end
        endcase
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 24) begin
            if (lat == 1) cmd_valid = 1'b0;
            tick();
            lat++;
        end
        cmd_valid = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_valid", {63'h0, rsp_valid}, 64'h1);
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", {63'h0, rsp_err}, {63'h0, exp_err});
        got = rsp_data;
        held = rsp_data;
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            chk("hold_valid", {63'h0, rsp_valid}, 64'h1);
            chk("hold_data", rsp_data, held);
            chk("hold_ready", {63'h0, cmd_ready}, 64'h0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_done", {63'h0, rsp_valid}, 64'h0);
        chk("back_idle", {63'h0, cmd_ready}, 64'h1);
        chk("wr_count", 64'(wr_q.size() - wstart), 64'(exp_nw));
        if (exp_nw == 3 && wr_q.size() - wstart == 3) begin
            exp_w[0] = {1'b1, 1'b0, 32'hFFFF_FFFF};
            exp_w[1] = {1'b1, 1'b1, tgt[63:32]};
            exp_w[2] = {1'b1, 1'b0, tgt[31:0]};
            for (int i = 0; i < 3; i++) chk("wr_trace", 64'(wr_q[wstart + i]), 64'(exp_w[i]));
            chk("mtimecmp", mtimecmp_m, tgt);
        end
        chaos = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, cmp_prev;
        int ic, wstart;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) tick();
        tb_init = 1'b0;
        chk("rst_ready", {63'h0, cmd_ready}, 64'h1);
        chk("rst_valid", {63'h0, rsp_valid}, 64'h0);
        chk("rst_data", rsp_data, 64'h0);
        chk("rst_err", {63'h0, rsp_err}, 64'h0);
        chk("rst_tsel", {62'h0, t_reg_sel, t_h_sel}, 64'h0);
        chk("rst_twdata", {32'h0, t_wdata}, 64'h0);
        chk("rst_twen", {63'h0, t_wenable}, 64'h0);
        rst_n = 1'b1;

        // READ accepted at the tenth edge after the last reset edge.
        repeat (9) tick();
        run_cmd(2'b00, 64'h0, 1'b0, 64'h0, 1'b0, 0, 1'b0, got);
        chk("s037_data", got, 64'h0000_0000_0000_000B);

        // READ across the low-word wrap.
        run_cmd(2'b00, 64'h0, 1'b1, 64'h0000_0000_FFFF_FFFE, 1'b0, 0, 1'b0, got);
`ifdef MTIME_INITIATOR_RETRY_EN
        chk("s038_hi", {32'h0, got[63:32]}, 64'h1);
        chk("s038_lo_small", {63'h0, got[31:0] < 32'h10}, 64'h1);
`else
        chk("s038_noretry", got, 64'h0000_0000_FFFF_FFFF);
`endif

        // ARM_ABS with no interrupt during the update.
        ic = int_cnt;
        run_cmd(2'b01, 64'h0000_0002_0000_0100, 1'b0, 64'h0, 1'b0, 0, 1'b1, got);
        chk("s039_int_cnt", 64'(int_cnt - ic), 64'h0);
        chk("s039_cmp", mtimecmp_m, 64'h0000_0002_0000_0100);

        // ARM_REL wrapping target.
        run_cmd(2'b10, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h0000_0000_0000_001F, 1'b0, 0, 1'b0, got);
        chk("s040_data", got, 64'h10);
        chk("s040_int", {63'h0, int_pending}, 64'h1);

        // DISARM with a stalled consumer.
        run_cmd(2'b11, 64'h1234, 1'b0, 64'h0, 1'b0, 5, 1'b1, got);
        chk("s041_cmp", mtimecmp_m, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("s041_int", {63'h0, int_pending}, 64'h0);

        // High word unstable every cycle.
        run_cmd(2'b00, 64'h0, 1'b0, 64'h0, 1'b1, 1, 1'b0, got);
        run_cmd(2'b10, 64'h55, 1'b0, 64'h0, 1'b1, 0, 1'b1, got);

        // Randomized commands.
        for (int n = 0; n < 24; n++) begin
            logic [63:0] d, p;
            bit dp;
            d  = {$urandom, $urandom};
            dp = ($urandom_range(0, 2) == 0);
            p  = {$urandom, 32'hFFFF_FFFF - 32'($urandom_range(0, 3))};
            run_cmd(2'($urandom_range(0, 3)), d, dp, p, ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
        end

        // Reset while in W_HI.
        cmp_prev = mtimecmp_m;
        wstart = wr_q.size();
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 64'h0000_0003_0000_0300;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rst_whi_wen", {63'h0, t_wenable}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_whi_gated", {63'h0, t_wenable}, 64'h0);
        repeat (2) begin
            tick();
            chk("rst_whi_valid", {63'h0, rsp_valid}, 64'h0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("rst_rel_ready", {63'h0, cmd_ready}, 64'h1);
            chk("rst_rel_valid", {63'h0, rsp_valid}, 64'h0);
        end
        chk("rst_whi_wrs", 64'(wr_q.size() - wstart), 64'h1);
        chk("rst_whi_cmp", mtimecmp_m, {cmp_prev[63:32], 32'hFFFF_FFFF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mtime_initiator.md
MTIME_INITIATOR -- requirements
Module: mtime_initiator

Interface
REQ-001 The block SHALL have parameter MAX_RETRY, default 3: the maximum number of hi-lo-hi re-reads before rsp_err is flagged.
REQ-002 clk  input  1  clock, shared with the timer block.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_op  input  2  00 READ, 01 ARM_ABS, 10 ARM_REL, 11 DISARM.
REQ-007 cmd_data  input  64  absolute target (ARM_ABS) or delta (ARM_REL); ignored otherwise.
REQ-008 rsp_valid  output  1  response available, held until rsp_ready.
REQ-009 rsp_ready  input  1  response consumed.
REQ-010 rsp_data  output  64  sampled mtime (READ) or value written to mtimecmp (arm/disarm ops).
REQ-011 rsp_err  output  1  retry limit exhausted; qualified by rsp_valid.
REQ-012 t_reg_sel  output  1  timer register select: 0 mtime, 1 mtimecmp.
REQ-013 t_h_sel  output  1  timer half select: 0 low word, 1 high word.
REQ-014 t_wdata  output  32  timer write data.
REQ-015 t_wenable  output  1  timer write strobe; the write commits at the next clk edge.
REQ-016 t_rdata  input  32  timer read data, combinational from {t_reg_sel, t_h_sel} in the same cycle.

Function
REQ-017 States SHALL be IDLE, RD_HI1, RD_LO, RD_HI2, W_LO_MAX, W_HI, W_LO and RESP; cmd_ready = (state==IDLE).
REQ-018 Acceptance SHALL latch op and data; READ and ARM_REL go to RD_HI1, while ARM_ABS and DISARM go to W_LO_MAX.
REQ-019 Each RD_* state SHALL drive t_reg_sel=0 with the matching half and sample t_rdata in that cycle: RD_HI1 to hi1, RD_LO to lo, RD_HI2 to hi2.
REQ-020 In RD_HI2, if hi2==hi1 the sample SHALL be {hi1,lo}; otherwise hi1<=hi2, the retry count increments and the state returns to RD_LO.
REQ-021 When the retry count reaches MAX_RETRY, the block SHALL go to RESP with rsp_err=1 and rsp_data={hi2,lo}, and SHALL issue no writes.
REQ-022 ARM_REL target SHALL be sample+delta modulo 2^64 (carry out discarded); then go to W_LO_MAX.
REQ-023 The write sequence SHALL be, one cycle each, t_reg_sel=1 throughout:
- W_LO_MAX: h_sel=0, wdata=0xFFFFFFFF.
- W_HI: h_sel=1, wdata=target[63:32].
- W_LO: h_sel=0, wdata=target[31:0].
REQ-024 DISARM target SHALL be 64'hFFFFFFFF_FFFFFFFF; the same three writes are issued.
REQ-025 t_wenable SHALL be 1 only in the W_* states, and 0 while rst_n is low (combinationally gated).
REQ-026 RESP SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready; rsp_valid && rsp_ready returns to IDLE.
- No new command is accepted in the same cycle.
REQ-027 Latency from acceptance edge to rsp_valid SHALL be, with no retry:
- READ: 4 cycles.
- ARM_ABS and DISARM: 4 cycles.
- ARM_REL: 7 cycles.
- Each retry adds 2 cycles.
REQ-028 rsp_valid with rsp_ready already high SHALL complete in 1 cycle; cmd_valid while busy SHALL be ignored, not queued.

Reset
REQ-029 While rst_n is low at a clk edge, the following SHALL hold: state=IDLE, retry=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-030 In IDLE and reset, timer-side outputs SHALL be t_reg_sel=0, t_h_sel=0, t_wdata=0, t_wenable=0.
REQ-031 Reset mid-sequence SHALL abort with no further writes and no response; a partially written mtimecmp is left as is.

Configuration
REQ-032 Macro MTIME_INITIATOR_RETRY_EN defined: hi-lo-hi retry per REQ-020/021 is compiled in.
REQ-033 Macro MTIME_INITIATOR_RETRY_EN undefined: RD_HI2 SHALL be omitted, the sample is {hi1,lo} and rsp_err is tied to 0.
- READ and ARM_REL latencies are reduced by 1 cycle.

Structure
REQ-034 Package mtime_initiator_pkg SHALL hold:
- op encodings.
- The state enum.
- Timer address constants MTIME_LO=00, MTIME_HI=01, MTIMECMP_LO=10, MTIMECMP_HI=11.
- The disarm constant.
REQ-035 The hi-lo-hi snapshot logic MAY be a sub-module mtime_snap; all other logic SHALL be flat.

Verification
REQ-036 Benches SHALL run against a cycle-accurate timer model; mtime=0 at reset and increments each clk.
REQ-037 Scenario: READ accepted 10 cycles after reset, rsp_ready=1 -> rsp_valid 4 cycles later, rsp_data=0x0000_0000_0000_000B (low word sampled at cycle 11), rsp_err=0.
REQ-038 Scenario: model preloaded mtime=0x00000000_FFFFFFFE, READ -> one retry, rsp_data[63:32]=0x00000001, rsp_data[31:0]<0x10, rsp_err=0.
REQ-039 Scenario: ARM_ABS 0x00000002_00000100 -> exact write trace: (10,FFFFFFFF), (11,00000002), (10,00000100).
- Final mtimecmp = 0x00000002_00000100.
- Model int_pending never asserts during the sequence.
REQ-040 Scenario: ARM_REL delta=0xFFFFFFFF_FFFFFFF0 with sample 0x20 -> target wraps to 0x10; rsp_data=0x10; int_pending asserts.
REQ-041 Scenario: DISARM -> mtimecmp=all ones, int_pending=0; rsp_ready held low for 5 cycles keeps rsp_valid and rsp_data stable, with cmd_ready=0.
REQ-042 Scenario: rst_n low during W_HI -> t_wenable=0 that cycle, no W_LO write, no rsp_valid, and cmd_ready=1 after reset release.
